// File: rtl/tone_arbiter.sv
// Tone arbiter: shares one differential piezo between NUM_REQ sound sources.
// Grants one request at a time, plays a square wave of half-period div+1 cycles for
// dur*TICK_DIV cycles, then holds a silent gap of GAP_TICKS*TICK_DIV cycles.
// Optional build macro TONE_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest requesting index wins.
module tone_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned TICK_DIV  = 25000,
    parameter int unsigned GAP_TICKS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*15-1:0] div_flat,
    input  logic [NUM_REQ*10-1:0] dur_flat,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic                  spkp,
    output logic                  spkm
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GapW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PreW-1:0] PreLoad = PreW'(TICK_DIV - 1);
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_TICKS);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] win_q, win_d;
    logic [14:0]     div_q, div_d;
    logic [14:0]     tone_q, tone_d;
    logic [9:0]      dur_q, dur_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            spk_q, spk_d;

    logic [IdxW-1:0] sel;
    logic            any_req;
    logic            req_win;
    logic            complete;
    logic            tone_on;

    assign any_req  = |req;
    assign req_win  = req[win_q];
    // dur=0 completes on the first PLAY cycle; otherwise on the last tick's final cycle
    assign complete = (dur_q == 10'd0) || ((dur_q == 10'd1) && (pre_q == '0));

`ifdef TONE_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0] ptr_q, ptr_d;

    // Round-robin winner: search starts just after the last granted index
    always_comb begin
        int cand;
        cand = 0;
        sel  = '0;
        // Descending distance so the nearest requester after ptr_q is written last
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            cand = (int'(ptr_q) + k) % int'(NUM_REQ);
            if (req[cand]) sel = IdxW'(cand);
        end
    end

    // Last-grant pointer; reset value makes requester 0 favoured first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= IdxW'(NUM_REQ - 1);
        else        ptr_q <= ptr_d;
    end

    // Pointer follows every grant, so aborted tones also move it on
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StIdle && any_req) ptr_d = sel;
    end
`else
    // Fixed-priority winner: lowest requesting index
    always_comb begin
        sel = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) sel = IdxW'(i);
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            win_q   <= '0;
            div_q   <= '0;
            tone_q  <= '0;
            dur_q   <= '0;
            pre_q   <= '0;
            gap_q   <= '0;
            spk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            div_q   <= div_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            pre_q   <= pre_d;
            gap_q   <= gap_d;
            spk_q   <= spk_d;
        end
    end

    // Next-state: grant, tone divider, duration prescaler and gap timer
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        div_d   = div_q;
        tone_d  = tone_q;
        dur_d   = dur_q;
        pre_d   = pre_q;
        gap_d   = gap_q;
        spk_d   = spk_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StPlay;
                    win_d   = sel;
                    div_d   = div_flat[int'(sel)*15 +: 15];
                    tone_d  = div_flat[int'(sel)*15 +: 15];
                    dur_d   = dur_flat[int'(sel)*10 +: 10];
                    pre_d   = PreLoad;
                    spk_d   = 1'b0;
                end
            end

            StPlay: begin
                if (tone_q == 15'd0) begin
                    tone_d = div_q;
                    spk_d  = ~spk_q;
                end else begin
                    tone_d = tone_q - 15'd1;
                end

                if (pre_q == '0) begin
                    pre_d = PreLoad;
                    if (dur_q != 10'd0) dur_d = dur_q - 10'd1;
                end else begin
                    pre_d = pre_q - PreW'(1);
                end

                // Abort and normal completion both lead to the gap; abort just skips done
                if (!req_win || complete) begin
                    state_d = StGap;
                    pre_d   = PreLoad;
                    gap_d   = GapLoad;
                    spk_d   = 1'b0;
                end
            end

            StGap: begin
                if (pre_q == '0) begin
                    pre_d = PreLoad;
                    if (gap_q != '0) gap_d = gap_q - GapW'(1);
                end else begin
                    pre_d = pre_q - PreW'(1);
                end

                if ((gap_q == '0) || ((gap_q == GapW'(1)) && (pre_q == '0))) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Outputs: grant for the whole PLAY, done only on an unaborted completion
    always_comb begin
        gnt  = '0;
        done = '0;
        if (state_q == StPlay) begin
            gnt[win_q] = 1'b1;
            if (req_win && complete) done[win_q] = 1'b1;
        end
    end

    // Drive the piezo only while a non-silent tone plays; both pins low otherwise
    always_comb begin
        busy    = (state_q != StIdle);
        tone_on = (state_q == StPlay) && (div_q != 15'd0);
        spkp    = tone_on & spk_q;
        spkm    = tone_on & ~spk_q;
    end

endmodule

// File: tb/tb_tone_arbiter.sv
// Scoreboard bench for tone_arbiter (NUM_REQ=3, TICK_DIV=4, GAP_TICKS=2).
// Stimulus pushes predicted tones; a negedge monitor pops and checks each tone and gap.
module tb_tone_arbiter;

    localparam int N    = 3;
    localparam int TD   = 4;
    localparam int GT   = 2;
    localparam int GAPC = (GT == 0) ? 1 : GT * TD;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]    req;
    logic [N*15-1:0] div_flat;
    logic [N*10-1:0] dur_flat;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            busy;
    logic            spkp;
    logic            spkm;

    always #5 clk = ~clk;

    tone_arbiter #(
        .NUM_REQ  (N),
        .TICK_DIV (TD),
        .GAP_TICKS(GT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .div_flat(div_flat),
        .dur_flat(dur_flat),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .spkp    (spkp),
        .spkm    (spkm)
    );

    typedef struct {
        int idx;
        int dv;
        int len;
        int dn;
    } tone_t;

    tone_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    model_last = N - 1;
    bit    mon_en = 1'b0;
    int    mstate = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference arbitration choice among pending requesters
    function automatic int pick(input logic [N-1:0] pend);
`ifdef TONE_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (model_last + k) % N;
            if (pend[j]) return j;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (pend[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic set_tone(input int i, input int d, input int u);
        div_flat[i*15 +: 15] = 15'(d);
        dur_flat[i*10 +: 10] = 10'(u);
    endtask

    // All requests raised together from IDLE and held until their done: serve in pick order
    task automatic start(input logic [N-1:0] r);
        logic [N-1:0] pend;
        tone_t        t;
        int           du;
        pend = r;
        while (pend != 0) begin
            t.idx = pick(pend);
            t.dv  = int'(div_flat[t.idx*15 +: 15]);
            du    = int'(dur_flat[t.idx*10 +: 10]);
            t.len = (du == 0) ? 1 : du * TD;
            t.dn  = 1;
            exp_q.push_back(t);
            model_last = t.idx;
            pend[t.idx] = 1'b0;
        end
        req = r;
    endtask

    // Requesters release their line on the edge after their done pulse
    task automatic serve(input int bound);
        logic [N-1:0] d;
        int           cyc;
        cyc = 0;
        while (req != 0 && cyc < bound) begin
            @(negedge clk);
            d = done;
            @(posedge clk);
            #1;
            req = req & ~d;
            cyc++;
        end
        chk("serve_released", longint'(req), 0);
        req = '0;
    endtask

    task automatic wait_idle();
        int cyc;
        bit ok;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            ok = (busy == 1'b0) && (mstate == 0) && (exp_q.size() == 0);
        end while (!ok && cyc < 400);
        chk("idle_reached", longint'(ok), 1);
        exp_q.delete();
    endtask

    // Monitor state
    tone_t        cur;
    logic [N-1:0] eg;
    int           cyc_m;
    int           wave_err;
    int           done_cyc;
    int           stray;
    int           gap_cnt;
    int           gap_err;

    task automatic sample_play();
        bit e;
        bit em;
        e  = (cur.dv != 0) && ((((cyc_m - 1) / (cur.dv + 1)) % 2) == 1);
        em = (cur.dv != 0) && !e;
        if (spkp !== e || spkm !== em || busy !== 1'b1 || gnt !== eg) wave_err++;
        if (done != 0) begin
            if (done == eg && done_cyc == 0) done_cyc = cyc_m;
            else stray++;
        end
    endtask

    task automatic sample_gap();
        if (busy && gnt == 0) begin
            gap_cnt++;
            if (spkp || spkm || done != 0) gap_err++;
        end else begin
            chk("gap_len", gap_cnt, GAPC);
            chk("gap_silent", gap_err, 0);
            mstate = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            mstate = 0;
        end else begin
            case (mstate)
                0: begin
                    if (gnt != 0) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_grant", longint'(gnt), 0);
                            cur = '{0, 0, 0, 0};
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        eg = '0;
                        eg[cur.idx] = 1'b1;
                        chk("grant", longint'(gnt), longint'(eg));
                        cyc_m    = 1;
                        wave_err = 0;
                        done_cyc = 0;
                        stray    = 0;
                        sample_play();
                        mstate = 1;
                    end
                end
                1: begin
                    if (gnt != 0) begin
                        cyc_m++;
                        sample_play();
                    end else begin
                        chk("play_len", cyc_m, cur.len);
                        chk("done_cycle", done_cyc, (cur.dn != 0) ? cur.len : 0);
                        chk("stray_done", stray, 0);
                        chk("wave", wave_err, 0);
                        gap_cnt = 0;
                        gap_err = 0;
                        mstate  = 2;
                        sample_gap();
                    end
                end
                default: sample_gap();
            endcase
        end
    end

    initial begin
        tone_t t;
        logic [N-1:0] r;

        req      = '0;
        div_flat = '0;
        dur_flat = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt", longint'(gnt), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_spkp", longint'(spkp), 0);
        chk("rst_spkm", longint'(spkm), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single tone
        set_tone(0, 2, 3);
        start(3'b001);
        serve(200);
        wait_idle();

        // Contention
        set_tone(1, 3, 1);
        set_tone(2, 1, 1);
        start(3'b110);
        serve(200);
        wait_idle();

        // Silent tone and zero duration
        set_tone(0, 0, 2);
        start(3'b001);
        serve(200);
        wait_idle();
        set_tone(1, 4, 0);
        start(3'b010);
        serve(200);
        wait_idle();

        // Latching: divider change mid-PLAY must be ignored
        set_tone(0, 2, 3);
        start(3'b001);
        repeat (6) @(posedge clk);
        #1;
        set_tone(0, 5, 3);
        serve(200);
        wait_idle();

        // Abort in PLAY cycle 5
        set_tone(0, 1, 3);
        t = '{0, 1, 5, 0};
        exp_q.push_back(t);
        model_last = 0;
        req = 3'b001;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        req = '0;
        wait_idle();

        // Randomized contention
        for (int ep = 0; ep < 25; ep++) begin
            r = 3'($urandom_range(1, 7));
            for (int i = 0; i < N; i++) begin
                set_tone(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            end
            start(r);
            serve(400);
            wait_idle();
        end

        // Asynchronous reset mid-PLAY
        mon_en = 1'b0;
        set_tone(0, 3, 3);
        req = 3'b001;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", longint'(gnt), 0);
        chk("arst_done", longint'(done), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_spkp", longint'(spkp), 0);
        chk("arst_spkm", longint'(spkm), 0);
        model_last = N - 1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("regrant_before_edge", longint'(gnt), 0);
        @(posedge clk);
        #1;
        chk("regrant_gnt", longint'(gnt), 1);
        chk("regrant_busy", longint'(busy), 1);
        model_last = 0;
        req = '0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tone_arbiter.md
Name: tone_arbiter

Overview:
- Shares the single differential speaker between NUM_REQ sound sources (siren, beeper, melody player, ...).
- Each requester asks for one tone: a half-period divider plus a duration.
- The arbiter grants one request at a time, generates the square wave with a reload/toggle divider, and times the duration.
- Inserts a silent gap between tones. Sits between the sound-source blocks and the spkp/spkm pins.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TICK_DIV, 25000, clk cycles per duration tick (1 ms at 25 MHz).
- GAP_TICKS, 20, silent ticks inserted after every tone; 0 = no gap.

Ports:
- clk  in  1  system clock (25 MHz PLL output).
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; level, held until done.
- div_flat  in  NUM_REQ*15  per-requester half-period divider; requester i at [15i+14:15i].
- dur_flat  in  NUM_REQ*10  per-requester duration in ticks; requester i at [10i+9:10i].
- gnt  out  NUM_REQ  one-hot; high for the whole PLAY of the granted requester.
- done  out  NUM_REQ  one-cycle pulse when a tone completes normally.
- busy  out  1  high in PLAY and GAP.
- spkp  out  1  speaker positive.
- spkm  out  1  speaker negative.

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; gnt=0, done=0, busy=0, spkp=0, spkm=0.
- All counters and latches are cleared.
- Reset mid-tone silences the output immediately; no done pulse.

States IDLE, PLAY, GAP. All transitions are on posedge clk.

IDLE:
- If req!=0, select a winner: fixed priority, lowest index wins.
- Latch its div and dur; go to PLAY.
- gnt is asserted at the next edge (1-cycle latency from req).
- Prescaler loads TICK_DIV-1, tone counter loads div, speaker=0.

PLAY, tone:
- Counter decrements each cycle.
- At 0: reload the latched div and toggle speaker.
- Half-period is div+1 cycles.
- div=0 means silence: speaker held 0 for the duration.

PLAY, duration:
- Prescaler decrements each cycle; at 0 it reloads TICK_DIV-1 and decrements the remaining duration.
- When the remaining duration is 1 and the prescaler hits 0: pulse done[winner], drop gnt, go to GAP.
- PLAY lasts exactly dur*TICK_DIV cycles.
- dur=0: done pulses the first cycle in PLAY, and PLAY lasts 1 cycle.

PLAY, abort:
- If req[winner] drops during PLAY: gnt drops next edge, no done pulse, go to GAP.
- Abort takes precedence if it coincides with completion.

Outputs:
- spkp=speaker and spkm=~speaker only while in PLAY with div!=0.
- Otherwise spkp=spkm=0 (no DC across the piezo).

Latching and contention:
- div and dur are sampled only on grant; later input changes are ignored until the next grant.
- Losing requests stay pending, with no queueing beyond the req level.
- A new req arriving during PLAY/GAP is considered at the next IDLE.

GAP:
- Silent for GAP_TICKS*TICK_DIV cycles, then IDLE.
- GAP_TICKS=0 gives 1 cycle in GAP.
- Back-to-back tones therefore never share a cycle of grant.

Width rules:
- Tone counter is 15 bits; duration counter is 10 bits; the prescaler is sized to fit TICK_DIV-1.
- No counter wraps: every reload happens at 0.

Optional Feature:
- Macro: TONE_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The search starts at the index after the last granted requester, wrapping NUM_REQ-1 to 0. The last-grant pointer resets to NUM_REQ-1, so the first grant after reset favours requester 0. Abort also updates the pointer.
- Undefined: fixed priority, lowest index wins; no pointer register exists.

Test Plan (NUM_REQ=3, TICK_DIV=4, GAP_TICKS=2):
1. Single tone:
   - Stimulus: req=001, div0=2, dur0=3.
   - Response: gnt=001 one cycle later. spkp toggles every 3 cycles, spkm=~spkp. done[0] pulses at cycle 12 of PLAY. Then 8 silent GAP cycles with spkp=spkm=0 and busy=1, then IDLE.
2. Contention:
   - Stimulus: req=110, all dur=1.
   - Response (fixed): gnt=010, then after the gap gnt=100.
   - Response (TONE_ARB_ROUND_ROBIN_EN, req=111 held): grants cycle 001→010→100→001.
3. Abort:
   - Stimulus: req0 drops in cycle 5 of PLAY.
   - Response: gnt=0 next edge, done stays 0, speaker outputs 0, GAP entered.
4. Edge values:
   - div=0, dur=2 → 8 cycles of PLAY with gnt high, spkp=spkm=0, done pulses.
   - dur=0 → done pulses after 1 PLAY cycle.
5. Async reset:
   - Stimulus: rst_n low mid-PLAY, asynchronous to clk.
   - Response: gnt, done, busy, spkp, spkm all 0 immediately. After release, a held req is re-granted from IDLE with 1-cycle latency.
6. Latching: change div0 from 2 to 5 mid-PLAY → toggle period stays 3 cycles until the tone ends.
